// File: rtl/apb_intercon_v3_pkg.sv
// Shared definitions for the APB interconnect: FSM encoding, arbitration modes and
// the width rule for the optional ACCESS watchdog counter.
package apb_intercon_v3_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StErr    = 2'd3
  } apb_ic_state_e;

  localparam int unsigned APB_ARB_RR    = 0;
  localparam int unsigned APB_ARB_FIXED = 1;

  localparam int unsigned APB_IC_TIMEOUT_W = 8;

  // Counter is 8 bits unless the limit needs more, capped at 16.
  function automatic int unsigned timeout_width(int unsigned cycles);
    return (cycles > 255) ? 16 : APB_IC_TIMEOUT_W;
  endfunction

endpackage

// File: rtl/apb_ic_arbiter_rr.sv
// Request arbiter for the APB interconnect: round-robin or fixed-priority one-hot grant.
// The round-robin pointer only moves when the owner takes a grant (advance_i).
module apb_ic_arbiter_rr #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] reqs_i,
  input  logic         advance_i,
  input  logic         mode_i,
  output logic [N-1:0] grant_o
);

  if (N == 1) begin : g_single
    assign grant_o = 1'b1;
    logic unused_arb;
    assign unused_arb = ^{clk, reset_n, reqs_i, advance_i, mode_i};
  end else begin : g_multi
    localparam int unsigned IdxW = $clog2(N);

    logic [IdxW-1:0] ptr_q, ptr_d;

    always_comb begin
      int unsigned start;
      int unsigned idx;
      int unsigned gidx;
      logic        found;
      grant_o = '0;
      found   = 1'b0;
      gidx    = 0;
      // Fixed priority is round-robin with the search anchored at master 0.
      start   = mode_i ? 0 : int'(ptr_q);
      for (int unsigned off = 0; off < N; off++) begin
        idx = start + off;
        if (idx >= N) idx = idx - N;
        if (!found && reqs_i[idx]) begin
          grant_o[idx] = 1'b1;
          gidx         = idx;
          found        = 1'b1;
        end
      end
      ptr_d = ptr_q;
      if (advance_i && found) begin
        ptr_d = (gidx == N - 1) ? '0 : IdxW'(gidx + 1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end
  end

endmodule

// File: rtl/apb_intercon_v3.sv
// Registered multi-master APB interconnect: latches one granted request, replays SETUP/ACCESS
// to the decoded slave and routes the response back. Optional watchdog: APB_IC_TIMEOUT_EN.
module apb_intercon_v3
  import apb_intercon_v3_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MASTER_PORTS   = 4,
  parameter int unsigned SLAVE_PORTS    = 16,
  parameter int unsigned ADDR_MSB       = 7,
  parameter int unsigned ADDR_LSB       = 4,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned PSEL_RANGE    = 2 ** (ADDR_MSB - ADDR_LSB + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [MASTER_PORTS-1:0]            S_PSLVERR,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic [PSEL_RANGE-1:0]              M_PSELx,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [PSEL_RANGE*DATA_WIDTH-1:0]   M_PRDATA,
  input  logic [PSEL_RANGE-1:0]              M_PREADY,
  input  logic [PSEL_RANGE-1:0]              M_PSLVERR
);

  localparam int unsigned SlotW = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned GIdxW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;

  apb_ic_state_e          state_q, state_d;
  logic [GIdxW-1:0]       g_q, g_d;
  logic [BUS_WIDTH-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [SlotW-1:0]       slot_q, slot_d;

  logic [MASTER_PORTS-1:0] arb_grant;
  logic [GIdxW-1:0]        arb_idx;
  logic                    advance;
  logic                    slv_ready;
  logic                    req_held;
  logic                    to_expire;

  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  assign advance   = (state_q == StIdle) && (|S_PSELx);
  assign slv_ready = M_PREADY[slot_q];
  // A requester that has let go of PSEL gets no response; the slave side still completes.
  assign req_held  = S_PSELx[g_q];

  apb_ic_arbiter_rr #(
    .N(MASTER_PORTS)
  ) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .reqs_i   (S_PSELx),
    .advance_i(advance),
    .mode_i   (ARB_MODE == APB_ARB_FIXED),
    .grant_o  (arb_grant)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
      if (arb_grant[i]) arb_idx = GIdxW'(i);
    end
  end

`ifdef APB_IC_TIMEOUT_EN
  localparam int unsigned ToW = timeout_width(TIMEOUT_CYCLES);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Cleared outside ACCESS, so every ACCESS phase starts counting from zero.
  assign to_cnt_d  = (state_q == StAccess && !slv_ready) ? to_cnt_q + 1'b1 : '0;
  assign to_expire = (32'(to_cnt_q) >= TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    slot_d  = slot_q;
    case (state_q)
      StIdle: begin
        if (|S_PSELx) begin
          g_d     = arb_idx;
          addr_d  = S_PADDR[int'(arb_idx)*BUS_WIDTH +: BUS_WIDTH];
          write_d = S_PWRITE[arb_idx];
          wdata_d = S_PWDATA[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          slot_d  = addr_d[ADDR_MSB:ADDR_LSB];
          state_d = (32'(slot_d) < SLAVE_PORTS) ? StSetup : StErr;
        end
      end
      StSetup:  state_d = StAccess;
      StAccess: begin
        if (slv_ready) begin
          state_d = StIdle;
        end else if (to_expire) begin
          state_d = StErr;
        end
      end
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      g_q     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      slot_q  <= slot_d;
    end
  end

  assign M_PADDR  = addr_q;
  assign M_PWRITE = write_q;
  assign M_PWDATA = wdata_q;

  always_comb begin
    M_PSELx   = '0;
    M_PENABLE = 1'b0;
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    case (state_q)
      StSetup: M_PSELx[slot_q] = 1'b1;
      StAccess: begin
        M_PSELx[slot_q] = 1'b1;
        M_PENABLE       = 1'b1;
        if (slv_ready && req_held) begin
          S_PREADY[g_q]  = 1'b1;
          S_PSLVERR[g_q] = M_PSLVERR[slot_q];
          S_PRDATA[int'(g_q)*DATA_WIDTH +: DATA_WIDTH] =
              M_PRDATA[int'(slot_q)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      StErr: begin
        if (req_held) begin
          S_PREADY[g_q]  = 1'b1;
          S_PSLVERR[g_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_intercon_v3.sv
// Bench for apb_intercon_v3: a round-robin and a fixed-priority instance, each checked every
// cycle against a transaction-level model, plus directed scenarios with literal expectations.
module tb_apb_intercon_v3;

  localparam int NI = 2;
  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NS = 16;
  localparam int SLAVES = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM*AW-1:0] s_paddr   [NI];
  logic [NM-1:0]    s_pwrite  [NI];
  logic [NM-1:0]    s_psel    [NI];
  logic [NM-1:0]    s_penable [NI];
  logic [NM*DW-1:0] s_pwdata  [NI];
  logic [NM*DW-1:0] s_prdata  [NI];
  logic [NM-1:0]    s_pready  [NI];
  logic [NM-1:0]    s_pslverr [NI];
  logic [AW-1:0]    m_paddr   [NI];
  logic             m_pwrite  [NI];
  logic [NS-1:0]    m_psel    [NI];
  logic             m_penable [NI];
  logic [DW-1:0]    m_pwdata  [NI];
  logic [NS*DW-1:0] m_prdata  [NI];
  logic [NS-1:0]    m_pready  [NI];
  logic [NS-1:0]    m_pslverr [NI];

  apb_intercon_v3 #(
    .MASTER_PORTS(NM), .SLAVE_PORTS(SLAVES), .ARB_MODE(0)
  ) u_dut_rr (
    .clk(clk), .reset_n(reset_n),
    .S_PADDR(s_paddr[0]), .S_PWRITE(s_pwrite[0]), .S_PSELx(s_psel[0]),
    .S_PENABLE(s_penable[0]), .S_PWDATA(s_pwdata[0]), .S_PRDATA(s_prdata[0]),
    .S_PREADY(s_pready[0]), .S_PSLVERR(s_pslverr[0]),
    .M_PADDR(m_paddr[0]), .M_PWRITE(m_pwrite[0]), .M_PSELx(m_psel[0]),
    .M_PENABLE(m_penable[0]), .M_PWDATA(m_pwdata[0]), .M_PRDATA(m_prdata[0]),
    .M_PREADY(m_pready[0]), .M_PSLVERR(m_pslverr[0])
  );

  apb_intercon_v3 #(
    .MASTER_PORTS(NM), .SLAVE_PORTS(SLAVES), .ARB_MODE(1)
  ) u_dut_fp (
    .clk(clk), .reset_n(reset_n),
    .S_PADDR(s_paddr[1]), .S_PWRITE(s_pwrite[1]), .S_PSELx(s_psel[1]),
    .S_PENABLE(s_penable[1]), .S_PWDATA(s_pwdata[1]), .S_PRDATA(s_prdata[1]),
    .S_PREADY(s_pready[1]), .S_PSLVERR(s_pslverr[1]),
    .M_PADDR(m_paddr[1]), .M_PWRITE(m_pwrite[1]), .M_PSELx(m_psel[1]),
    .M_PENABLE(m_penable[1]), .M_PWDATA(m_pwdata[1]), .M_PRDATA(m_prdata[1]),
    .M_PREADY(m_pready[1]), .M_PSLVERR(m_pslverr[1])
  );

  int tests = 0;
  int fails = 0;

  // Transaction-level model: one outstanding transfer per instance, tracked by its age.
  bit            mbusy  [NI];
  int            mage   [NI];
  int            mg     [NI];
  int            mslot  [NI];
  int            mlast  [NI];
  logic [AW-1:0] maddr  [NI];
  logic [DW-1:0] mwdata [NI];
  logic          mwrite [NI];
  logic [NM-1:0] exp_prev [NI];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mbusy[k]    = 1'b0;
      mage[k]     = 0;
      mlast[k]    = NM - 1;
      exp_prev[k] = '0;
    end
  endtask

  task automatic model_step(int k);
    logic [NS-1:0]    e_sel;
    logic             e_en;
    logic [NM-1:0]    e_rdy;
    logic [NM-1:0]    e_err;
    logic [NM*DW-1:0] e_rdata;
    string            p;
    int               g;
    p       = $sformatf("i%0d", k);
    e_sel   = '0;
    e_en    = 1'b0;
    e_rdy   = '0;
    e_err   = '0;
    e_rdata = '0;
    if (!reset_n) begin
      model_reset();
      check({p, " rst m_paddr"}, 64'(m_paddr[k]), 64'd0);
      check({p, " rst m_pwdata"}, 64'(m_pwdata[k]), 64'd0);
      check({p, " rst m_pwrite"}, 64'(m_pwrite[k]), 64'd0);
    end else if (mbusy[k]) begin
      if (mslot[k] < SLAVES) begin
        e_sel[mslot[k]] = 1'b1;
        e_en = (mage[k] >= 2);
        check({p, " m_paddr"}, 64'(m_paddr[k]), 64'(maddr[k]));
        check({p, " m_pwrite"}, 64'(m_pwrite[k]), 64'(mwrite[k]));
        check({p, " m_pwdata"}, 64'(m_pwdata[k]), 64'(mwdata[k]));
        if (e_en && m_pready[k][mslot[k]]) begin
          if (s_psel[k][mg[k]]) begin
            e_rdy[mg[k]] = 1'b1;
            e_err[mg[k]] = m_pslverr[k][mslot[k]];
            e_rdata[mg[k]*DW +: DW] = m_prdata[k][mslot[k]*DW +: DW];
          end
          mbusy[k] = 1'b0;
        end else begin
          mage[k]++;
        end
      end else begin
        if (s_psel[k][mg[k]]) begin
          e_rdy[mg[k]] = 1'b1;
          e_err[mg[k]] = 1'b1;
        end
        mbusy[k] = 1'b0;
      end
    end else if (|s_psel[k]) begin
      g = -1;
      for (int off = 0; off < NM; off++) begin
        int i;
        i = (k == 1) ? off : (mlast[k] + 1 + off) % NM;
        if (g < 0 && s_psel[k][i]) g = i;
      end
      mg[k]     = g;
      mlast[k]  = g;
      maddr[k]  = s_paddr[k][g*AW +: AW];
      mwrite[k] = s_pwrite[k][g];
      mwdata[k] = s_pwdata[k][g*DW +: DW];
      mslot[k]  = (int'(maddr[k]) >> 4) & 15;
      mbusy[k]  = 1'b1;
      mage[k]   = 1;
    end
    check({p, " m_psel"}, 64'(m_psel[k]), 64'(e_sel));
    check({p, " m_penable"}, 64'(m_penable[k]), 64'(e_en));
    check({p, " s_pready"}, 64'(s_pready[k]), 64'(e_rdy));
    check({p, " s_pslverr"}, 64'(s_pslverr[k]), 64'(e_err));
    check({p, " s_prdata"}, 64'(s_prdata[k]), 64'(e_rdata));
    exp_prev[k] = e_rdy;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
  endtask

  task automatic end_cycle();
    for (int k = 0; k < NI; k++) s_penable[k] = s_psel[k];
    #1;
    for (int k = 0; k < NI; k++) model_step(k);
  endtask

  task automatic set_master(int m, logic sel, logic [AW-1:0] addr, logic wr, logic [DW-1:0] wd);
    for (int k = 0; k < NI; k++) begin
      s_psel[k][m]            = sel;
      s_paddr[k][m*AW +: AW]  = addr;
      s_pwrite[k][m]          = wr;
      s_pwdata[k][m*DW +: DW] = wd;
    end
  endtask

  task automatic set_slaves(logic [NS-1:0] rdy, logic [NS-1:0] err);
    for (int k = 0; k < NI; k++) begin
      m_pready[k]  = rdy;
      m_pslverr[k] = err;
      for (int s = 0; s < NS; s++) m_prdata[k][s*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("async rst m_psel", 64'(m_psel[0]), 64'd0);
    check("async rst m_penable", 64'(m_penable[0]), 64'd0);
    check("async rst m_paddr", 64'(m_paddr[0]), 64'd0);
    check("async rst s_pready", 64'(s_pready[0]), 64'd0);
    check("async rst s_prdata", 64'(s_prdata[0]), 64'd0);
    model_reset();
    begin_cycle();
    end_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [NI][5];
    int n [NI];
    int exp_rr [5];
    for (int k = 0; k < NI; k++) begin
      s_paddr[k] = '0; s_pwrite[k] = '0; s_psel[k] = '0; s_penable[k] = '0;
      s_pwdata[k] = '0; m_prdata[k] = '0; m_pready[k] = '0; m_pslverr[k] = '0;
    end
    model_reset();

    // Reset state
    begin_cycle();
    end_cycle();
    check("reset m_psel", 64'(m_psel[0]), 64'd0);
    check("reset s_pready", 64'(s_pready[1]), 64'd0);
    begin_cycle();
    reset_n = 1'b1;
    end_cycle();

    // Zero-wait write of 0xBEEF to 0x0023 (slave 2)
    begin_cycle();
    set_master(0, 1'b1, 16'h0023, 1'b1, 16'hBEEF);
    set_slaves('1, '0);
    end_cycle();
    check("wr c0 s_pready", 64'(s_pready[0]), 64'd0);
    begin_cycle();
    end_cycle();
    check("wr c1 m_psel", 64'(m_psel[0]), 64'h0004);
    check("wr c1 m_penable", 64'(m_penable[0]), 64'd0);
    check("wr c1 m_pwdata", 64'(m_pwdata[0]), 64'hBEEF);
    check("wr c1 m_paddr", 64'(m_paddr[0]), 64'h0023);
    begin_cycle();
    end_cycle();
    check("wr c2 m_penable", 64'(m_penable[0]), 64'd1);
    check("wr c2 s_pready", 64'(s_pready[0]), 64'b0001);
    check("wr c2 s_pslverr", 64'(s_pslverr[0]), 64'd0);
    begin_cycle();
    set_master(0, 1'b0, 16'h0023, 1'b1, 16'hBEEF);
    end_cycle();
    check("wr c3 s_pready", 64'(s_pready[0]), 64'd0);

    // Arbitration order with all masters requesting continuously
    do_reset();
    begin_cycle();
    reset_n = 1'b1;
    for (int m = 0; m < NM; m++) set_master(m, 1'b1, AW'(16'h0010 + m), 1'b0, '0);
    set_slaves('1, '0);
    end_cycle();
    for (int k = 0; k < NI; k++) begin
      n[k] = 0;
      for (int j = 0; j < 5; j++) ord[k][j] = -1;
    end
    for (int c = 0; c < 40 && (n[0] < 5 || n[1] < 5); c++) begin
      begin_cycle();
      end_cycle();
      for (int k = 0; k < NI; k++) begin
        for (int i = 0; i < NM; i++) begin
          if (s_pready[k][i] && n[k] < 5) begin
            ord[k][n[k]] = i;
            n[k]++;
          end
        end
      end
    end
    exp_rr = '{0, 1, 2, 3, 0};
    for (int j = 0; j < 5; j++) begin
      check($sformatf("rr grant %0d", j), 64'(ord[0][j]), 64'(exp_rr[j]));
      check($sformatf("fixed grant %0d", j), 64'(ord[1][j]), 64'd0);
    end
    begin_cycle();
    for (int m = 0; m < NM; m++) set_master(m, 1'b0, '0, 1'b0, '0);
    end_cycle();
    begin_cycle();
    end_cycle();

    // Read from slave 5 with three wait states, master 2
    begin_cycle();
    set_master(2, 1'b1, 16'h0050, 1'b0, '0);
    set_slaves('0, '0);
    end_cycle();
    for (int c = 1; c <= 4; c++) begin
      begin_cycle();
      set_slaves('0, '0);
      for (int k = 0; k < NI; k++) m_prdata[k][5*DW +: DW] = 16'h1234;
      end_cycle();
      check($sformatf("rd c%0d s_pready", c), 64'(s_pready[0]), 64'd0);
      check($sformatf("rd c%0d s_prdata", c), 64'(s_prdata[0]), 64'd0);
    end
    begin_cycle();
    set_slaves(16'h0020, '0);
    for (int k = 0; k < NI; k++) m_prdata[k][5*DW +: DW] = 16'h1234;
    end_cycle();
    check("rd c5 s_pready", 64'(s_pready[0]), 64'b0100);
    check("rd c5 s_prdata", 64'(s_prdata[0]), 64'h0000_1234_0000_0000);
    begin_cycle();
    set_master(2, 1'b0, '0, 1'b0, '0);
    end_cycle();

    // Unmapped slot 10
    begin_cycle();
    set_master(1, 1'b1, 16'h00A0, 1'b0, '0);
    set_slaves('1, '1);
    end_cycle();
    begin_cycle();
    end_cycle();
    check("unmapped m_psel", 64'(m_psel[0]), 64'd0);
    check("unmapped s_pready", 64'(s_pready[0]), 64'b0010);
    check("unmapped s_pslverr", 64'(s_pslverr[0]), 64'b0010);
    check("unmapped s_prdata", 64'(s_prdata[0]), 64'd0);
    begin_cycle();
    set_master(1, 1'b0, '0, 1'b0, '0);
    end_cycle();
    check("unmapped after s_pready", 64'(s_pready[0]), 64'd0);

    // Reset during ACCESS, then RR restarts at master 0
    begin_cycle();
    set_master(0, 1'b1, 16'h0030, 1'b1, 16'h5A5A);
    set_slaves('0, '0);
    end_cycle();
    begin_cycle();
    end_cycle();
    begin_cycle();
    end_cycle();
    check("pre-reset m_penable", 64'(m_penable[0]), 64'd1);
    do_reset();
    begin_cycle();
    reset_n = 1'b1;
    set_master(1, 1'b1, 16'h0030, 1'b0, '0);
    set_slaves('1, '0);
    end_cycle();
    begin_cycle();
    end_cycle();
    check("post-reset m_psel", 64'(m_psel[0]), 64'h0008);
    check("post-reset m_penable", 64'(m_penable[0]), 64'd0);
    begin_cycle();
    end_cycle();
    check("post-reset grant", 64'(s_pready[0]), 64'b0001);
    begin_cycle();
    set_master(0, 1'b0, '0, 1'b0, '0);
    set_master(1, 1'b0, '0, 1'b0, '0);
    end_cycle();

    // Randomized traffic; masters hold PSEL until PREADY, occasionally abandoning a request
    for (int c = 0; c < 3000; c++) begin
      begin_cycle();
      for (int k = 0; k < NI; k++) begin
        for (int i = 0; i < NM; i++) begin
          if (s_psel[k][i]) begin
            if (exp_prev[k][i] || $urandom_range(0, 63) == 0) s_psel[k][i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            s_psel[k][i]            = 1'b1;
            s_paddr[k][i*AW +: AW]  = {8'($urandom), 4'($urandom_range(0, 10)), 4'($urandom)};
            s_pwrite[k][i]          = 1'($urandom);
            s_pwdata[k][i*DW +: DW] = DW'($urandom);
          end
        end
        m_pready[k]  = NS'($urandom);
        m_pslverr[k] = NS'($urandom);
        for (int s = 0; s < NS; s++) m_prdata[k][s*DW +: DW] = DW'($urandom);
      end
      end_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
